// File: rtl/cla16_bist_if.sv
// ============================================================================
// Module      : cla16_bist_if
// Description : Operand/result/status bundle between cla16_bist and its adder
//               plus controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cla16_bist_if;
    logic        start;
    logic [15:0] dut_x;
    logic [15:0] dut_y;
    logic [15:0] dut_z;
    logic        dut_carry;
    logic        dut_zero;
    logic        dut_parity;
    logic        dut_sign;
    logic        dut_overflow;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] fail_count;
    logic [15:0] first_fail_idx;

    // BIST engine side
    modport master (
        input  start, dut_z, dut_carry, dut_zero, dut_parity, dut_sign, dut_overflow,
        output dut_x, dut_y, busy, done, pass, fail_count, first_fail_idx
    );

    // Adder and controller side
    modport slave (
        output start, dut_z, dut_carry, dut_zero, dut_parity, dut_sign, dut_overflow,
        input  dut_x, dut_y, busy, done, pass, fail_count, first_fail_idx
    );
endinterface

`default_nettype wire

// File: rtl/cla16_bist.sv
// ============================================================================
// Module      : cla16_bist
// Description : Self-test engine for the 16-bit CLA adder: 6 corner vectors
//               then NUM_VECTORS LFSR vectors, one compare per clock.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cla16_bist #(
    parameter int          NUM_VECTORS = 1024,
    parameter logic [15:0] SEED_X      = 16'hACE1,
    parameter logic [15:0] SEED_Y      = 16'h1D2B
) (
    input  logic          clk,
    input  logic          rst,
    cla16_bist_if.master  bus
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;

    localparam logic [15:0] C_LAST_IDX   = 16'(NUM_VECTORS + 5);
    localparam logic [15:0] C_LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] C_FIRST_RAND = 16'd6;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? C_LFSR_TAPS : 16'h0000);
    endfunction

    logic [1:0]  r_state;
    logic [15:0] r_idx;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_lfsr_x;
    logic [15:0] r_lfsr_y;
    logic [15:0] r_fail_count;
    logic [15:0] r_first_fail;
    logic        r_pass;

    logic [16:0] w_sum;
    logic [15:0] w_z;
    logic        w_overflow;
    logic        w_mismatch;
    logic [15:0] w_fail_next;
    logic [15:0] w_idx_next;
    logic [15:0] w_dir_x;
    logic [15:0] w_dir_y;

    // Reference model for the operands currently presented to the adder
    assign w_sum      = {1'b0, r_x} + {1'b0, r_y};
    assign w_z        = w_sum[15:0];
    assign w_overflow = (r_x[15] == r_y[15]) && (w_z[15] != r_x[15]);
    assign w_mismatch = (bus.dut_z        != w_z)
                     || (bus.dut_carry    != w_sum[16])
                     || (bus.dut_zero     != (w_z == 16'h0000))
                     || (bus.dut_parity   != ~^w_z)
                     || (bus.dut_sign     != w_z[15])
                     || (bus.dut_overflow != w_overflow);

    assign w_fail_next = (w_mismatch && (r_fail_count != 16'hFFFF))
                       ? r_fail_count + 16'd1 : r_fail_count;
    assign w_idx_next  = r_idx + 16'd1;

    always_comb begin
        w_dir_x = 16'h0000;
        w_dir_y = 16'h0000;
        case (w_idx_next)
            16'd1:   begin w_dir_x = 16'h00FF; w_dir_y = 16'hFF00; end
            16'd2:   begin w_dir_x = 16'h0F0F; w_dir_y = 16'hF0F0; end
            16'd3:   begin w_dir_x = 16'hFFFF; w_dir_y = 16'h0001; end
            16'd4:   begin w_dir_x = 16'h7FFF; w_dir_y = 16'h0001; end
            16'd5:   begin w_dir_x = 16'h8000; w_dir_y = 16'h8000; end
            default: begin w_dir_x = 16'h0000; w_dir_y = 16'h0000; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= 16'h0000;
            r_x          <= 16'h0000;
            r_y          <= 16'h0000;
            r_lfsr_x     <= 16'h0000;
            r_lfsr_y     <= 16'h0000;
            r_fail_count <= 16'h0000;
            r_first_fail <= 16'h0000;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state      <= S_RUN;
                        r_idx        <= 16'h0000;
                        r_x          <= 16'h0000;
                        r_y          <= 16'h0000;
                        r_lfsr_x     <= SEED_X;
                        r_lfsr_y     <= SEED_Y;
                        r_fail_count <= 16'h0000;
                        r_first_fail <= 16'h0000;
                        r_pass       <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_fail_count <= w_fail_next;
                    if (w_mismatch && (r_fail_count == 16'h0000)) begin
                        r_first_fail <= r_idx;
                    end
                    if (r_idx == C_LAST_IDX) begin
                        // Resolve pass here so it is already valid during DONE
                        r_state <= S_DONE;
                        r_pass  <= (w_fail_next == 16'h0000);
                    end else begin
                        r_idx <= w_idx_next;
                        if (w_idx_next >= C_FIRST_RAND) begin
                            r_x      <= r_lfsr_x;
                            r_y      <= r_lfsr_y;
                            r_lfsr_x <= lfsr_step(r_lfsr_x);
                            r_lfsr_y <= lfsr_step(r_lfsr_y);
                        end else begin
                            r_x <= w_dir_x;
                            r_y <= w_dir_y;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_x          = r_x;
    assign bus.dut_y          = r_y;
    assign bus.busy           = (r_state == S_RUN);
    assign bus.done           = (r_state == S_DONE);
    assign bus.pass           = r_pass;
    assign bus.fail_count     = r_fail_count;
    assign bus.first_fail_idx = r_first_fail;

endmodule

`default_nettype wire
